// File: rtl/regfile_write_arbiter.sv
// Round-robin write arbiter (A/B) over NREGS x W storage with a sequenced CLEAR; writes land 1 cycle after handshake.
// Backpressure: combinational ready, held low during CLEAR and whenever init is requested; nothing is buffered.
module regfile_write_arbiter #(
  parameter int             NREGS    = 8,
  parameter int             W        = 8,
  parameter bit             ZERO_REG = 1'b1,
  parameter logic [W-1:0]   INIT_VAL = '0
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               init,
  input  logic               a_valid,
  output logic               a_ready,
  input  logic [3:0]         a_addr,
  input  logic [W-1:0]       a_data,
  input  logic               b_valid,
  output logic               b_ready,
  input  logic [3:0]         b_addr,
  input  logic [W-1:0]       b_data,
  output logic [NREGS*W-1:0] regs_flat,
  output logic               busy,
  output logic               err_addr,
  output logic [7:0]         wr_count
);

  localparam int CW = (NREGS > 1) ? $clog2(NREGS) : 1;

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] CLEAR = 1'b1;

  logic [0:0]   state;
  logic [CW-1:0] cnt;
  logic         prio;          // 0: A wins a tie, 1: B wins a tie
  logic [W-1:0] regs [NREGS];

  logic         open_win;
  logic         xfer;
  logic [3:0]   wr_addr;
  logic [W-1:0] wr_data;
  logic         in_range;
  logic         to_zero;

  assign open_win = rst_n && (state == IDLE) && !init;
  assign a_ready  = open_win && a_valid && (!b_valid || !prio);
  assign b_ready  = open_win && b_valid && (!a_valid || prio);
  assign xfer     = a_ready || b_ready;

  assign wr_addr  = a_ready ? a_addr : b_addr;
  assign wr_data  = a_ready ? a_data : b_data;
  assign in_range = int'(wr_addr) < NREGS;
  assign to_zero  = ZERO_REG && (wr_addr == 4'd0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      cnt      <= '0;
      prio     <= 1'b0;
      busy     <= 1'b0;
      err_addr <= 1'b0;
      wr_count <= 8'd0;
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
    end else begin
      err_addr <= 1'b0;
      case (state)
        IDLE: begin
          if (init) begin
            state <= CLEAR;
            cnt   <= '0;
            busy  <= 1'b1;
          end else if (xfer) begin
            prio <= a_ready;
            if (!in_range) begin
              err_addr <= 1'b1;
            end else if (!to_zero) begin
              wr_count <= wr_count + 8'd1;
              for (int i = 0; i < NREGS; i++)
                if (int'(wr_addr) == i) regs[i] <= wr_data;
            end
          end
        end
        default: begin
          // One register per cycle; the $zero register is never touched.
          for (int i = 0; i < NREGS; i++)
            if (int'(cnt) == i && !(ZERO_REG && i == 0)) regs[i] <= INIT_VAL;
          cnt <= cnt + 1'b1;
          if (cnt == CW'(NREGS - 1)) begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
      endcase
    end
  end

  for (genvar g = 0; g < NREGS; g++) begin : g_flat
    assign regs_flat[g*W +: W] = regs[g];
  end

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Randomised and directed stimulus for regfile_write_arbiter, checked against a register-array model.
module tb_regfile_write_arbiter;

  localparam int NR = 8;
  localparam logic [7:0] IV = 8'hC3;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          init = 1'b0;
  logic          a_valid = 1'b0, b_valid = 1'b0;
  logic          a_ready, b_ready;
  logic [3:0]    a_addr = '0, b_addr = '0;
  logic [7:0]    a_data = '0, b_data = '0;
  logic [63:0]   regs_flat;
  logic          busy, err_addr;
  logic [7:0]    wr_count;

  regfile_write_arbiter #(.NREGS(NR), .W(8), .ZERO_REG(1'b1), .INIT_VAL(IV)) dut (
    .clk(clk), .rst_n(rst_n), .init(init),
    .a_valid(a_valid), .a_ready(a_ready), .a_addr(a_addr), .a_data(a_data),
    .b_valid(b_valid), .b_ready(b_ready), .b_addr(b_addr), .b_data(b_data),
    .regs_flat(regs_flat), .busy(busy), .err_addr(err_addr), .wr_count(wr_count)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: plain array plus "registers left to clear".
  logic [7:0] mregs [NR];
  int         mcount;
  bit         mprio;     // 1 means B is favoured on a tie
  int         mclr;
  bit         merr;
  bit         ga, gb;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [63:0] model_flat();
    logic [63:0] f;
    for (int i = 0; i < NR; i++) f[i*8 +: 8] = mregs[i];
    return f;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NR; i++) mregs[i] = 8'h00;
    mcount = 0; mprio = 1'b0; mclr = 0; merr = 1'b0; ga = 1'b0; gb = 1'b0;
  endtask

  // Called at posedge+1 or later; asserts reset away from edges and checks reset values.
  task automatic apply_reset();
    rst_n = 1'b0;
    a_valid = 1'b1; b_valid = 1'b1; init = 1'b0;
    #1;
    chk("rst_a_ready", a_ready, 0);
    chk("rst_b_ready", b_ready, 0);
    chk("rst_regs", regs_flat, 0);
    chk("rst_busy", busy, 0);
    chk("rst_err", err_addr, 0);
    chk("rst_wr_count", wr_count, 0);
    model_reset();
    a_valid = 1'b0; b_valid = 1'b0;
    #1 rst_n = 1'b1;
  endtask

  // One clock: check ready at negedge, advance model, check state after the edge.
  task automatic cycle();
    logic ea, eb;
    int   addr;
    logic [7:0] data;
    @(negedge clk);
    ea = rst_n && (mclr == 0) && !init && a_valid && (!b_valid || !mprio);
    eb = rst_n && (mclr == 0) && !init && b_valid && (!a_valid || mprio);
    chk("a_ready", a_ready, ea);
    chk("b_ready", b_ready, eb);
    ga = ea; gb = eb;
    merr = 1'b0;
    if (mclr == 0) begin
      if (init) mclr = NR;
      else if (ea || eb) begin
        addr  = ea ? int'(a_addr) : int'(b_addr);
        data  = ea ? a_data : b_data;
        mprio = ea;
        if (addr >= NR) merr = 1'b1;
        else if (addr != 0) begin
          mregs[addr] = data;
          mcount = (mcount + 1) % 256;
        end
      end
    end else begin
      if (NR - mclr != 0) mregs[NR - mclr] = IV;
      mclr--;
    end
    @(posedge clk); #1;
    chk("busy", busy, (mclr != 0));
    chk("err_addr", err_addr, merr);
    chk("wr_count", wr_count, mcount[7:0]);
    chk("regs_flat", regs_flat, model_flat());
  endtask

  initial begin
    int n;
    logic [7:0] last;
    model_reset();
    @(posedge clk); #1;

    // 1: single A write
    apply_reset();
    a_valid = 1; a_addr = 4'd3; a_data = 8'h5A;
    cycle();
    chk("t1_reg3", regs_flat[31:24], 8'h5A);
    chk("t1_wr_count", wr_count, 8'd1);
    a_valid = 0;

    // 2: contention, A first then B
    apply_reset();
    a_valid = 1; a_addr = 4'd1; a_data = 8'h11;
    b_valid = 1; b_addr = 4'd2; b_data = 8'h22;
    cycle();
    chk("t2_first_grant_a", ga, 1);
    if (ga) a_valid = 0;
    cycle();
    chk("t2_second_grant_b", gb, 1);
    b_valid = 0;
    chk("t2_regs12", regs_flat[23:8], 16'h2211);
    chk("t2_wr_count", wr_count, 8'd2);

    // 3: zero register and out-of-range address
    b_valid = 1; b_addr = 4'd0; b_data = 8'hFF;
    cycle();
    chk("t3_reg0", regs_flat[7:0], 8'h00);
    chk("t3_wc_zero", wr_count, 8'd2);
    b_addr = 4'd9; b_data = 8'hEE;
    cycle();
    chk("t3_err_pulse", err_addr, 1);
    chk("t3_wc_err", wr_count, 8'd2);
    b_valid = 0;
    cycle();
    chk("t3_err_clear", err_addr, 0);

    // 4: CLEAR with a write waiting
    a_valid = 1; a_addr = 4'd4; a_data = 8'h77; init = 1;
    cycle();
    init = 0;
    n = 0;
    while (busy && n < 20) begin
      n++;
      cycle();
    end
    chk("t4_busy_cycles", n, 8);
    chk("t4_cleared", regs_flat, 64'hC3C3C3C3_C3C3C300);
    cycle();
    chk("t4_a_write_after", regs_flat[39:32], 8'h77);
    a_valid = 0;

    // 5: init during CLEAR ignored, reset mid-CLEAR
    init = 1; cycle(); init = 0;
    cycle();
    init = 1; cycle(); init = 0;
    cycle();
    chk("t5_still_busy", busy, 1);
    apply_reset();
    a_valid = 1; a_addr = 4'd6; a_data = 8'h66;
    b_valid = 1; b_addr = 4'd7; b_data = 8'h99;
    cycle();
    chk("t5_prio_a", ga, 1);
    a_valid = 0; b_valid = 0;

    // 6: wr_count wraps after 256 writes
    apply_reset();
    a_valid = 1; a_addr = 4'd5;
    last = 8'h00;
    for (int i = 0; i < 256; i++) begin
      a_data = 8'($urandom);
      last = a_data;
      cycle();
    end
    chk("t6_wrap", wr_count, 8'd0);
    chk("t6_reg5", regs_flat[47:40], last);
    a_valid = 0;

    // Random traffic with occasional CLEAR and reset
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 499) == 0) apply_reset();
      if (ga) a_valid = 0;
      if (gb) b_valid = 0;
      if (!a_valid && $urandom_range(0, 9) < 6) begin
        a_valid = 1; a_addr = 4'($urandom_range(0, 11)); a_data = 8'($urandom);
      end
      if (!b_valid && $urandom_range(0, 9) < 6) begin
        b_valid = 1; b_addr = 4'($urandom_range(0, 11)); b_data = 8'($urandom);
      end
      init = ($urandom_range(0, 63) == 0);
      cycle();
    end
    init = 0;

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
